// File: rtl/rv_pkg.sv
// Shared constants and types for the RV multicycle datapath.
//   WB_*    : writeback source select (wbsel)
//   IMM_*   : immediate format select (immsel)
//   ALU_*   : ALU operation select (alusel)
//   ALUA_*  : ALU operand A select (asel)
//   ALUB_*  : ALU operand B select (bsel)
//   PC_*    : next-PC source select (pcsrc)
//   mem_size_e : access size, taken from ir[13:12]
package rv_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic [1:0] WB_MUL = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_COPYB = 4'd10;

    localparam logic ALUA_REG = 1'b0;
    localparam logic ALUA_PC  = 1'b1;
    localparam logic ALUB_REG = 1'b0;
    localparam logic ALUB_IMM = 1'b1;

    localparam logic PC_ALU    = 1'b0;  // combinational ALU result
    localparam logic PC_ALUOUT = 1'b1;  // registered ALU result

    typedef enum logic [1:0] {
        MemByte  = 2'b00,
        MemHalf  = 2'b01,
        MemWord  = 2'b10,
        MemDword = 2'b11
    } mem_size_e;

    // Byte-lane mask for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(mem_size_e sz);
        case (sz)
            MemByte: return 8'h01;
            MemHalf: return 8'h03;
            MemWord: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/rv_mul_iter.sv
// Iterative radix-2 shift-add multiplier returning the low DPWIDTH product bits.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : accepted only while busy is low; captures op_a/op_b
//   op_a, op_b      : operands
//   busy            : high for exactly DPWIDTH cycles after an accepted start
//   result          : product register, updated when the operation completes
module rv_mul_iter
    import rv_pkg::*;
#(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DPWIDTH-1:0] op_a,
    input  logic [DPWIDTH-1:0] op_b,
    output logic               busy,
    output logic [DPWIDTH-1:0] result
);

    localparam int CW = $clog2(DPWIDTH);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [DPWIDTH-1:0] mcand_q, mcand_d;
    logic [DPWIDTH-1:0] mplier_q, mplier_d;
    logic [DPWIDTH-1:0] acc_q, acc_d;
    logic [DPWIDTH-1:0] result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DPWIDTH-1:0] acc_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                // One multiplier bit per cycle; bits shifted past the top are
                // dropped, which leaves exactly the low half of the product.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(DPWIDTH - 1)) begin
                    result_d = acc_sum;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q == StBusy);
    assign result = result_q;

endmodule

// File: rtl/rv_dp_md.sv
// Multicycle RV datapath with lane-aligned load/store and an optional
// iterative multiply unit (compiled in when RV_DP_MUL_EN is defined).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   imem_addr / imem_datain  : instruction address (pc) / instruction word
//   dmem_addr                : data address (aluout)
//   dmem_dataout / dmem_be   : replicated store data / addressed byte lanes
//   dmem_datain              : load data, captured into mdr
//   instr / zero             : IR contents / ALU result is zero
//   pcsrc..mdrwrite          : 1-bit datapath controls
//   wbsel, immsel, alusel    : writeback, immediate and ALU selects
//   mul_start / mul_busy     : multiply-unit handshake
module rv_dp_md
    import rv_pkg::*;
#(
    parameter int DPWIDTH = 32,
    parameter int RFSIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [DPWIDTH-1:0]   imem_addr,
    input  logic [DPWIDTH-1:0]   imem_datain,
    output logic [DPWIDTH-1:0]   dmem_addr,
    output logic [DPWIDTH-1:0]   dmem_dataout,
    input  logic [DPWIDTH-1:0]   dmem_datain,
    output logic [DPWIDTH/8-1:0] dmem_be,
    output logic [DPWIDTH-1:0]   instr,
    output logic                 zero,
    input  logic                 pcsrc,
    input  logic                 pcwrite,
    input  logic                 pccen,
    input  logic                 irwrite,
    input  logic                 regwen,
    input  logic                 asel,
    input  logic                 bsel,
    input  logic                 mdrwrite,
    input  logic [1:0]           wbsel,
    input  logic [2:0]           immsel,
    input  logic [3:0]           alusel,
    input  logic                 mul_start,
    output logic                 mul_busy
);

    localparam int NB  = DPWIDTH / 8;
    localparam int LW  = $clog2(NB);
    localparam int SW  = $clog2(DPWIDTH);
    localparam int RIW = $clog2(RFSIZE);

    logic [DPWIDTH-1:0] pc_q, pcc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
    logic [DPWIDTH-1:0] rf_q [RFSIZE];

    logic [4:0]         rs1, rs2, rd;
    logic [DPWIDTH-1:0] rs1_data, rs2_data;
    logic [31:0]        imm32;
    logic [DPWIDTH-1:0] imm;
    logic [DPWIDTH-1:0] op_a, op_b, alu_result;
    logic [SW-1:0]      shamt;
    logic [DPWIDTH-1:0] pc_next, wb_data, ld_data, ld_lane, mul_result;
    mem_size_e          sz;
    logic [LW-1:0]      off, off_al;
    logic [NB-1:0]      be_mask;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    // Register file: x0 is never stored, reads of it return zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0 && 32'(rs1) < RFSIZE) rs1_data = rf_q[rs1[RIW-1:0]];
        if (rs2 != 5'd0 && 32'(rs2) < RFSIZE) rs2_data = rf_q[rs2[RIW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (regwen && rd != 5'd0 && 32'(rd) < RFSIZE) begin
            rf_q[rd[RIW-1:0]] <= wb_data;
        end
    end

    always_comb begin
        case (immsel)
            IMM_I:   imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J:   imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21],
                              1'b0};
            IMM_U:   imm32 = {ir_q[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm   = DPWIDTH'($signed(imm32));
    assign op_a  = (asel == ALUA_PC) ? pcc_q : a_q;
    assign op_b  = (bsel == ALUB_IMM) ? imm : b_q;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        alu_result = '0;
        case (alusel)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_SLL:   alu_result = op_a << shamt;
            ALU_SLT:   alu_result = DPWIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU:  alu_result = DPWIDTH'(op_a < op_b);
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SRL:   alu_result = op_a >> shamt;
            ALU_SRA:   alu_result = $signed(op_a) >>> shamt;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_COPYB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Access size and lane offset, shared by the store and load paths.
    always_comb begin
        sz = mem_size_e'(ir_q[13:12]);
        if (NB == 4 && sz == MemDword) sz = MemWord;
        off = aluout_q[LW-1:0];
        case (sz)
            MemByte: off_al = off;
            MemHalf: off_al = off & ~LW'(1);
            MemWord: off_al = off & ~LW'(3);
            default: off_al = '0;
        endcase
        be_mask = NB'(size_mask(sz));
    end

    assign dmem_be = be_mask << off_al;

    always_comb begin
        case (sz)
            MemByte: dmem_dataout = {NB{b_q[7:0]}};
            MemHalf: dmem_dataout = {(NB/2){b_q[15:0]}};
            MemWord: dmem_dataout = {(NB/4){b_q[31:0]}};
            default: dmem_dataout = b_q;
        endcase
    end

    // Load: bring the addressed lane down to bit 0, then extend; ir[14] set
    // means the unsigned (zero-extending) variant.
    assign ld_lane = mdr_q >> {off_al, 3'b000};

    always_comb begin
        case (sz)
            MemByte: ld_data = ir_q[14] ? DPWIDTH'(ld_lane[7:0])
                                        : DPWIDTH'($signed(ld_lane[7:0]));
            MemHalf: ld_data = ir_q[14] ? DPWIDTH'(ld_lane[15:0])
                                        : DPWIDTH'($signed(ld_lane[15:0]));
            MemWord: ld_data = ir_q[14] ? DPWIDTH'(ld_lane[31:0])
                                        : DPWIDTH'($signed(ld_lane[31:0]));
            default: ld_data = ld_lane;
        endcase
    end

    always_comb begin
        case (wbsel)
            WB_ALU:  wb_data = aluout_q;
            WB_MDR:  wb_data = ld_data;
            WB_PC:   wb_data = pc_q;
            default: wb_data = mul_result;
        endcase
    end

    assign pc_next = (pcsrc == PC_ALUOUT) ? aluout_q : alu_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            pcc_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (pcwrite)  pc_q  <= pc_next;
            if (pccen)    pcc_q <= pc_q;
            if (irwrite)  ir_q  <= imem_datain;
            if (mdrwrite) mdr_q <= dmem_datain;
            a_q      <= rs1_data;
            b_q      <= rs2_data;
            aluout_q <= alu_result;
        end
    end

    assign imem_addr = pc_q;
    assign dmem_addr = aluout_q;
    assign instr     = ir_q;

`ifdef RV_DP_MUL_EN
    rv_mul_iter #(
        .DPWIDTH(DPWIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .op_a  (a_q),
        .op_b  (b_q),
        .busy  (mul_busy),
        .result(mul_result)
    );
`else
    logic unused_mul_start;
    assign unused_mul_start = mul_start;
    assign mul_busy         = 1'b0;
    assign mul_result       = '0;
`endif

endmodule

// File: tb/tb_rv_dp_md.sv
// Directed bench for rv_dp_md: a 32-bit and a 64-bit instance share all
// controls; register contents are observed through word/dword stores.
module tb_rv_dp_md;
    import rv_pkg::*;

`ifdef RV_DP_MUL_EN
    localparam int          EXP_BUSY = 32;
    localparam logic [31:0] EXP_PROD = 32'hFFFF_FFEB;
`else
    localparam int          EXP_BUSY = 0;
    localparam logic [31:0] EXP_PROD = 32'h0;
`endif

    localparam logic [31:0] ADD_X5_X1_X2 = 32'h0020_82B3;
    localparam logic [31:0] ADD_X5_X1_X1 = 32'h0010_82B3;

    logic        clk, rst;
    logic        pcsrc, pcwrite, pccen, irwrite, regwen, asel, bsel, mdrwrite, mul_start;
    logic [1:0]  wbsel;
    logic [2:0]  immsel;
    logic [3:0]  alusel;
    logic [31:0] imem_w, dmem_in32;
    logic [63:0] dmem_in64;

    logic [31:0] imem_addr32, dmem_addr32, dmem_dataout32, instr32;
    logic [3:0]  dmem_be32;
    logic        zero32, mul_busy32;
    logic [63:0] imem_addr64, dmem_addr64, dmem_dataout64, instr64;
    logic [7:0]  dmem_be64;
    logic        zero64, mul_busy64;

    int n_vec = 0;
    int n_err = 0;

    rv_dp_md #(.DPWIDTH(32), .RFSIZE(32)) u_dut32 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr32), .imem_datain(imem_w),
        .dmem_addr(dmem_addr32), .dmem_dataout(dmem_dataout32), .dmem_datain(dmem_in32),
        .dmem_be(dmem_be32), .instr(instr32), .zero(zero32), .pcsrc(pcsrc),
        .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite), .regwen(regwen), .asel(asel),
        .bsel(bsel), .mdrwrite(mdrwrite), .wbsel(wbsel), .immsel(immsel), .alusel(alusel),
        .mul_start(mul_start), .mul_busy(mul_busy32)
    );

    rv_dp_md #(.DPWIDTH(64), .RFSIZE(32)) u_dut64 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr64), .imem_datain({32'h0, imem_w}),
        .dmem_addr(dmem_addr64), .dmem_dataout(dmem_dataout64), .dmem_datain(dmem_in64),
        .dmem_be(dmem_be64), .instr(instr64), .zero(zero64), .pcsrc(pcsrc),
        .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite), .regwen(regwen), .asel(asel),
        .bsel(bsel), .mdrwrite(mdrwrite), .wbsel(wbsel), .immsel(immsel), .alusel(alusel),
        .mul_start(mul_start), .mul_busy(mul_busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store table: funct3, then expected lanes/data for aluout = 0x103, x2 = 0xAB.
    logic [2:0]  st_f3   [2] = '{3'b000, 3'b001};
    logic [3:0]  st_be32 [2] = '{4'b1000, 4'b1100};
    logic [31:0] st_do32 [2] = '{32'hABAB_ABAB, 32'h00AB_00AB};
    logic [7:0]  st_be64 [2] = '{8'h08, 8'h0C};
    logic [63:0] st_do64 [2] = '{64'hABAB_ABAB_ABAB_ABAB, 64'h00AB_00AB_00AB_00AB};

    // Load table with mdr = 0x8001_1234: funct3, offset, expected writeback.
    logic [2:0]  ld_f3  [5] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010};
    logic [11:0] ld_off [5] = '{12'd2, 12'd2, 12'd3, 12'd1, 12'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80,
                                32'h0000_0012, 32'h8001_1234};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] w);
        imem_w  = w;
        irwrite = 1'b1;
        tick();
        irwrite = 1'b0;
    endtask

    task automatic alu_imm(input logic [2:0] sel);
        asel   = ALUA_REG;
        bsel   = ALUB_IMM;
        immsel = sel;
        alusel = ALU_ADD;
    endtask

    task automatic alu_rr();
        asel   = ALUA_REG;
        bsel   = ALUB_REG;
        alusel = ALU_ADD;
    endtask

    // addi rd, x0, imm
    task automatic set_reg(input logic [4:0] rd, input logic [11:0] imm);
        load_ir({imm, 5'd0, 3'b000, rd, 7'h13});
        alu_imm(IMM_I);
        tick();
        tick();
        wbsel  = WB_ALU;
        regwen = 1'b1;
        tick();
        regwen = 1'b0;
    endtask

    // sw r, 0(x0): the word store presents rs2 unchanged on dmem_dataout.
    task automatic read_reg(input logic [4:0] r, output logic [31:0] v32,
                            output logic [63:0] v64);
        load_ir({7'd0, r, 5'd0, 3'b010, 5'd0, 7'h23});
        alu_imm(IMM_S);
        tick();
        tick();
        v32 = dmem_dataout32;
        v64 = dmem_dataout64;
    endtask

    task automatic wb_mul();
        wbsel  = WB_MUL;
        regwen = 1'b1;
        tick();
        regwen = 1'b0;
    endtask

    // Pulse mul_start, then count busy cycles; optionally swap the IR (so a/b
    // change) and re-pulse mul_start during the busy window.
    task automatic run_mul(input int alt_at, input int restart_at, output int busy_n);
        busy_n    = 0;
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        for (int i = 1; i <= 200 && mul_busy32; i++) begin
            busy_n++;
            imem_w    = ADD_X5_X1_X1;
            irwrite   = (i == alt_at);
            mul_start = (i == restart_at);
            tick();
        end
        irwrite   = 1'b0;
        mul_start = 1'b0;
    endtask

    logic [31:0] v32;
    logic [63:0] v64;
    int          bn;

    initial begin
        rst = 1'b0;
        {pcsrc, pcwrite, pccen, irwrite, regwen, asel, bsel, mdrwrite, mul_start} = '0;
        wbsel = WB_ALU; immsel = IMM_I; alusel = ALU_ADD;
        imem_w = '0; dmem_in32 = '0; dmem_in64 = '0;
        repeat (3) tick();
        check("rst_pc", imem_addr32, 0);
        check("rst_ir", instr32, 0);
        check("rst_aluout", dmem_addr32, 0);
        check("rst_busy", mul_busy32, 0);
        check("rst_pc64", imem_addr64, 0);
        rst = 1'b1;
        tick();

        set_reg(5'd0, 12'h005);
        read_reg(5'd0, v32, v64);
        check("x0_drop", v32, 0);
        load_ir(32'h0000_0013);
        alu_imm(IMM_I);
        tick();
        tick();
        check("zero_set", zero32, 1);

        set_reg(5'd1, 12'h103);
        set_reg(5'd2, 12'h0AB);
        for (int i = 0; i < 2; i++) begin
            load_ir({7'd0, 5'd2, 5'd1, st_f3[i], 5'd0, 7'h23});
            alu_imm(IMM_S);
            tick();
            tick();
            check($sformatf("st_be32_%0d", i), dmem_be32, st_be32[i]);
            check($sformatf("st_do32_%0d", i), dmem_dataout32, st_do32[i]);
            check($sformatf("st_be64_%0d", i), dmem_be64, st_be64[i]);
            check($sformatf("st_do64_%0d", i), dmem_dataout64, st_do64[i]);
        end
        check("zero_clr", zero32, 0);
        pcsrc   = PC_ALU;
        pcwrite = 1'b1;
        tick();
        pcwrite = 1'b0;
        check("pc_alu", imem_addr32, 32'h103);

        set_reg(5'd4, 12'hFFF);
        load_ir({7'd0, 5'd4, 5'd0, 3'b011, 5'd0, 7'h23});
        alu_imm(IMM_S);
        tick();
        tick();
        check("sd_be64", dmem_be64, 8'hFF);
        check("sd_do64", dmem_dataout64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sd_be32", dmem_be32, 4'hF);
        check("sd_do32", dmem_dataout32, 32'hFFFF_FFFF);

        for (int i = 0; i < 5; i++) begin
            load_ir({ld_off[i], 5'd0, ld_f3[i], 5'd3, 7'h03});
            alu_imm(IMM_I);
            dmem_in32 = 32'h8001_1234;
            dmem_in64 = {32'h0, 32'h8001_1234};
            mdrwrite  = 1'b1;
            tick();
            tick();
            mdrwrite = 1'b0;
            wbsel    = WB_MDR;
            regwen   = 1'b1;
            tick();
            regwen = 1'b0;
            read_reg(5'd3, v32, v64);
            check($sformatf("ld32_%0d", i), v32, ld_exp[i]);
            check($sformatf("ld64_%0d", i), v64, {2{ld_exp[i]}});
        end

        set_reg(5'd1, 12'd7);
        set_reg(5'd2, 12'hFFD);
        load_ir(ADD_X5_X1_X2);
        alu_rr();
        tick();
        tick();
        run_mul(0, 0, bn);
        check("mul_busy_len", bn, EXP_BUSY);
        wb_mul();
        read_reg(5'd5, v32, v64);
        check("mul_prod", v32, EXP_PROD);

        load_ir(ADD_X5_X1_X2);
        alu_rr();
        tick();
        tick();
        run_mul(2, 5, bn);
        check("mul_restart_len", bn, EXP_BUSY);
        wb_mul();
        read_reg(5'd5, v32, v64);
        check("mul_restart_prod", v32, EXP_PROD);

        load_ir(ADD_X5_X1_X2);
        alu_rr();
        tick();
        tick();
        pcsrc   = PC_ALUOUT;
        pcwrite = 1'b1;
        tick();
        pcwrite = 1'b0;
        check("pc_aluout", imem_addr32, 32'h4);
        pccen = 1'b1;
        tick();
        pccen  = 1'b0;
        asel   = ALUA_PC;
        bsel   = ALUB_IMM;
        immsel = IMM_U;
        tick();
        tick();
        check("auipc32", dmem_addr32, 32'h0020_8004);
        check("auipc64", dmem_addr64, 64'h0020_8004);
        alu_rr();
        tick();
        tick();

        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        repeat (9) tick();
        check("busy_pre_rst", mul_busy32, EXP_BUSY != 0);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", mul_busy32, 0);
        check("rst_mid_pc", imem_addr32, 0);
        tick();
        rst = 1'b1;
        tick();
        check("busy_after_rst", mul_busy32, 0);
        load_ir(ADD_X5_X1_X2);
        alu_rr();
        tick();
        tick();
        run_mul(0, 0, bn);
        check("mul_post_rst_len", bn, EXP_BUSY);
        wb_mul();
        read_reg(5'd5, v32, v64);
        check("mul_post_rst_prod", v32, EXP_PROD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_dp_md.md
RV_DP_MD -- requirements
Module: rv_dp_md

Interface
REQ-001 SHALL have parameter DPWIDTH, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RFSIZE, default 32, register count; x0 is included and is not stored.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port imem_addr / imem_datain, out/in, DPWIDTH, instruction address and instruction word.
REQ-007 SHALL have port dmem_addr / dmem_dataout / dmem_datain, out/out/in, DPWIDTH, data address, store data and load data.
REQ-008 SHALL have port dmem_be, output, DPWIDTH/8, store byte enables.
REQ-009 SHALL have port instr / zero, output, DPWIDTH/1, IR contents and ALU-result-is-zero flag.
REQ-010 SHALL have ports pcsrc, pcwrite, pccen, irwrite, regwen, asel, bsel, mdrwrite, input, 1 each, with the same meaning as the current datapath.
REQ-011 SHALL have ports wbsel (2), immsel (3), alusel (4), input, writeback, immediate and ALU selects; immsel adds IMM_U.
REQ-012 SHALL have ports mul_start (input, 1) and mul_busy (output, 1), the multiply-unit handshake.

Function
REQ-013 SHALL implement pc, pcc, ir, a, b, aluout and mdr stage registers.
- pc/pcc/ir/mdr: load only when enabled.
- a/b/aluout: load every cycle.
- x0 reads as 0.
- Writes to x0 are dropped.
REQ-014 SHALL add IMM_U: {ir[31:12],12'b0}, sign-extended to DPWIDTH.
REQ-015 SHALL lane-align stores.
- Size comes from ir[13:12]: 00 byte, 01 half, 10 word, 11 dword (DPWIDTH=64 only).
- Lane offset is aluout[log2(DPWIDTH/8)-1:0], rounded down to size alignment.
- dmem_be sets only the addressed lanes.
- dmem_dataout replicates the low bytes of b into every lane.
REQ-016 SHALL select load data from mdr at the same lane, zero-extended when ir[14]=1 and sign-extended otherwise; wbsel=WB_MDR writes this extended value.
REQ-017 SHALL implement the multiply unit.
- mul_start=1 while mul_busy=0 captures a and b.
- mul_busy rises the next cycle and stays high exactly DPWIDTH cycles (radix-2 shift-add).
- The low DPWIDTH product bits are then held in a result register.
REQ-018 SHALL ignore mul_start asserted while mul_busy=1; the operation in flight is undisturbed.
REQ-019 SHALL select the multiply result register when wbsel=WB_MUL; the result stays stable until the next accepted start.
REQ-020 SHALL let any other datapath activity proceed unchanged while mul_busy=1.
REQ-021 SHALL make zero combinational on alu_result.

Reset
REQ-022 SHALL, when rst=0, asynchronously clear pc, pcc, ir, a, b, aluout, mdr, mul_busy, the multiplier state and the multiply result to 0; the register file is not reset.
REQ-023 SHALL abort an operation in flight on reset mid-multiply; mul_busy is 0 in the first cycle after rst rises.

Configuration
REQ-024 SHALL compile the multiply unit in when RV_DP_MUL_EN is defined.
REQ-025 SHALL, when RV_DP_MUL_EN is undefined, tie mul_busy to 0, ignore mul_start, make WB_MUL write 0, and instantiate no multiplier logic.

Structure
REQ-026 SHALL place the WB_*, IMM_*, ALU_*, ALUA_*, ALUB_* and PC_* constants, plus the mem-size enum, in shared package rv_pkg.
REQ-027 SHALL implement the multiplier as sub-module rv_mul_iter, parametrised by DPWIDTH, with a start/busy/result interface.

Verification
REQ-028 SHALL verify: DPWIDTH=32, store byte with aluout=0x103, b=0x000000AB -> dmem_be=4'b1000, dmem_dataout=0xABABABAB.
REQ-029 SHALL verify: load half with aluout=0x2, mdr=0x8001_1234, ir[14]=0 -> writeback 0xFFFF8001; with ir[14]=1 -> 0x00008001.
REQ-030 SHALL verify: a=7, b=-3, mul_start pulse -> mul_busy high 32 cycles, then WB_MUL writes 0xFFFFFFEB.
REQ-031 SHALL verify: second mul_start at busy cycle 5 -> ignored, same 32-cycle busy window, result unchanged.
REQ-032 SHALL verify: rst=0 at busy cycle 10 -> mul_busy=0 and pc=0 immediately; a new start after release -> correct product.
REQ-033 SHALL verify: build without RV_DP_MUL_EN, mul_start=1 -> mul_busy stays 0 and WB_MUL writes 0; DPWIDTH=64 dword store -> dmem_be=8'hFF.
